// File: rtl/sccb_pkg.sv
// Shared types and constants for the OV7670 SCCB init sequencer and its ROM.
package sccb_pkg;

  typedef enum logic [3:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DELAY,
    ST_ISSUE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_GAP,
    ST_NEXT,
    ST_IDLE
  } sccb_state_e;

  typedef enum logic {
    SRC_INIT,
    SRC_MAN
  } sccb_src_e;

  localparam logic [7:0] SCCB_WRITE_ADDR   = 8'h42;
  localparam logic [7:0] SCCB_DELAY_MARKER = 8'hFF;
  localparam logic [1:0] MODE_WRITE        = 2'b00;

  typedef struct packed {
    logic [7:0] sub;
    logic [7:0] data;
  } init_entry_t;

  function automatic logic is_delay_marker(input init_entry_t e);
    return e.sub == SCCB_DELAY_MARKER;
  endfunction

endpackage

// File: rtl/sccb_init_sequencer_rom.sv
// OV7670 register init table (QVGA RGB565), one {subaddress, data} entry per index.
module ov7670_init_rom
  import sccb_pkg::*;
#(
  parameter int NUM_REGS = 64,
  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [AW-1:0] index,
  output init_entry_t   entry
);

  logic [7:0] idx8;

  // Entry 1 is a delay marker: the camera needs settling time after the COM7 soft reset.
  always_comb begin
    idx8 = 8'(index);
    case (idx8)
      8'd0:  entry = 16'h1280;
      8'd1:  entry = 16'hFF02;
      8'd2:  entry = 16'h1101;
      8'd3:  entry = 16'h1204;
      8'd4:  entry = 16'h0C04;
      8'd5:  entry = 16'h3E19;
      8'd6:  entry = 16'h703A;
      8'd7:  entry = 16'h7135;
      8'd8:  entry = 16'h7211;
      8'd9:  entry = 16'h73F1;
      8'd10: entry = 16'hA202;
      8'd11: entry = 16'h40D0;
      8'd12: entry = 16'h8C00;
      8'd13: entry = 16'h3A04;
      8'd14: entry = 16'h3DC8;
      8'd15: entry = 16'h1418;
      8'd16: entry = 16'h4FB3;
      8'd17: entry = 16'h50B3;
      8'd18: entry = 16'h5100;
      8'd19: entry = 16'h523D;
      8'd20: entry = 16'h53A7;
      8'd21: entry = 16'h54E4;
      8'd22: entry = 16'h589E;
      8'd23: entry = 16'h1716;
      8'd24: entry = 16'h1804;
      8'd25: entry = 16'h3224;
      8'd26: entry = 16'h1902;
      8'd27: entry = 16'h1A7A;
      8'd28: entry = 16'h030A;
      8'd29: entry = 16'h0F41;
      8'd30: entry = 16'h1E00;
      8'd31: entry = 16'h330B;
      8'd32: entry = 16'h3C78;
      8'd33: entry = 16'h6900;
      8'd34: entry = 16'h7400;
      8'd35: entry = 16'hB084;
      8'd36: entry = 16'hB10C;
      8'd37: entry = 16'hB20E;
      8'd38: entry = 16'hB380;
      8'd39: entry = 16'h7A20;
      8'd40: entry = 16'h7B10;
      8'd41: entry = 16'h7C1E;
      8'd42: entry = 16'h7D35;
      8'd43: entry = 16'h7E5A;
      8'd44: entry = 16'h7F69;
      8'd45: entry = 16'h8076;
      8'd46: entry = 16'h8180;
      8'd47: entry = 16'h8288;
      8'd48: entry = 16'h838F;
      8'd49: entry = 16'h8496;
      8'd50: entry = 16'h85A3;
      8'd51: entry = 16'h86AF;
      8'd52: entry = 16'h87C4;
      8'd53: entry = 16'h88D7;
      8'd54: entry = 16'h89E8;
      8'd55: entry = 16'h13E0;
      8'd56: entry = 16'h0000;
      8'd57: entry = 16'h1000;
      8'd58: entry = 16'h0D40;
      8'd59: entry = 16'h1418;
      8'd60: entry = 16'hA505;
      8'd61: entry = 16'hAB07;
      8'd62: entry = 16'h2495;
      8'd63: entry = 16'h2533;
      // Out-of-table reads decode as a zero-length delay so they can never start a write.
      default: entry = {SCCB_DELAY_MARKER, 8'h00};
    endcase
  end

endmodule

// File: rtl/sccb_init_sequencer.sv
// Owns the i2c host command interface: writes the OV7670 init table after power-up,
// then forwards manual register commands one at a time.
module sccb_init_sequencer
  import sccb_pkg::*;
#(
  parameter int NUM_REGS     = 64,
  parameter int BOOT_CYCLES  = 1_000_000,
  parameter int GAP_CYCLES   = 256,
  parameter int DELAY_UNIT   = 10_000,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        m_req,
  input  logic [7:0]  m_subaddress,
  input  logic [7:0]  m_data,
  input  logic [1:0]  m_mode,
  output logic        m_ack,
  output logic        o_usher,
  output logic [7:0]  o_address,
  output logic [7:0]  o_subaddress,
  output logic [7:0]  o_data,
  output logic [1:0]  o_mode,
  input  logic        i_busy,
  output logic        init_done,
  output logic        timeout_err,
  output logic        seq_busy,
  output sccb_state_e dbg_state
);

  localparam int AW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  // One extra bit so the index can hold NUM_REGS itself, the end-of-table value.
  localparam int IW     = AW + 1;
  localparam int BOOT_W = $clog2(BOOT_CYCLES) + 1;
  localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;
  localparam int TO_W   = $clog2(BUSY_TIMEOUT) + 1;
  localparam int DLY_W  = $clog2(255 * DELAY_UNIT) + 1;

  sccb_state_e       state;
  sccb_src_e         src;
  logic [IW-1:0]     index;
  logic [BOOT_W-1:0] boot_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [DLY_W-1:0]  delay_cnt;
  init_entry_t       rom_entry;

  ov7670_init_rom #(.NUM_REGS(NUM_REGS)) u_rom (
    .index (index[AW-1:0]),
    .entry (rom_entry)
  );

  assign o_address = SCCB_WRITE_ADDR;
  assign seq_busy  = (state != ST_IDLE);
  assign dbg_state = state;

  // Handshakes: m_req is a level held by the requester until the one-cycle m_ack that
  // latches its command; o_usher is a one-cycle start that is only raised while i_busy
  // is low, and the host acknowledges it by raising i_busy and later dropping it.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      state        <= ST_BOOT;
      src          <= SRC_INIT;
      index        <= '0;
      boot_cnt     <= '0;
      gap_cnt      <= '0;
      to_cnt       <= '0;
      delay_cnt    <= '0;
      o_usher      <= 1'b0;
      m_ack        <= 1'b0;
      init_done    <= 1'b0;
      timeout_err  <= 1'b0;
      o_subaddress <= '0;
      o_data       <= '0;
      o_mode       <= '0;
    end else begin
      o_usher <= 1'b0;
      m_ack   <= 1'b0;
      case (state)
        ST_BOOT: begin
          if (boot_cnt == BOOT_W'(BOOT_CYCLES - 1)) state <= ST_FETCH;
          else boot_cnt <= boot_cnt + BOOT_W'(1);
        end
        ST_FETCH: begin
          if (is_delay_marker(rom_entry)) begin
            delay_cnt <= DLY_W'(32'(rom_entry.data) * 32'(DELAY_UNIT));
            state     <= ST_DELAY;
          end else begin
            o_subaddress <= rom_entry.sub;
            o_data       <= rom_entry.data;
            o_mode       <= MODE_WRITE;
            src          <= SRC_INIT;
            // Start straight away when the host is free; otherwise park in ISSUE.
            if (!i_busy) begin
              o_usher <= 1'b1;
              state   <= ST_WAIT_HI;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_DELAY: begin
          if (delay_cnt == '0) begin
            index <= index + IW'(1);
            state <= ST_NEXT;
          end else begin
            delay_cnt <= delay_cnt - DLY_W'(1);
          end
        end
        ST_ISSUE: begin
          if (!i_busy) begin
            o_usher <= 1'b1;
            state   <= ST_WAIT_HI;
          end
        end
        ST_WAIT_HI: begin
          if (i_busy) begin
            to_cnt <= '0;
            state  <= ST_WAIT_LO;
          end else if (to_cnt == TO_W'(BUSY_TIMEOUT - 1)) begin
            to_cnt      <= '0;
            timeout_err <= 1'b1;
            state       <= ST_GAP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!i_busy) state <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            gap_cnt <= '0;
            if (src == SRC_INIT) begin
              index <= index + IW'(1);
              state <= ST_NEXT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        ST_NEXT: begin
          if (index == IW'(NUM_REGS)) begin
            init_done <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            state <= ST_FETCH;
          end
        end
        ST_IDLE: begin
          if (m_req) begin
            o_subaddress <= m_subaddress;
            o_data       <= m_data;
            o_mode       <= m_mode;
            m_ack        <= 1'b1;
            src          <= SRC_MAN;
            state        <= ST_ISSUE;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

endmodule
